// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: PC latch, word-aligned req/ack memory read,
// hold for decode, one-cycle PCWre pulse per consumed instruction.
module ifetch_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic        halt,
  output logic        PCWre,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instr_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, UPD, FAULT} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc;
  logic [TW-1:0] tcount;
  logic [TW-1:0] tnext;

  assign tnext = tcount + TW'(1);

  // Next-state decode; an ack in the cycle the limit would be hit takes priority.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (!halt) begin
          if (Addr[1:0] != 2'b00) state_n = FAULT;
          else                    state_n = REQ;
        end
      end
      REQ: begin
        if (mem_ack)             state_n = HOLD;
        else if (tnext == TLIM)  state_n = FAULT;
      end
      HOLD:    if (instr_ready) state_n = UPD;
      UPD:     state_n = IDLE;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are flops loaded from the upcoming state so they line up with it.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state       <= IDLE;
      fetch_pc    <= '0;
      tcount      <= '0;
      PCWre       <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      instr_count <= '0;
    end else begin
      state       <= state_n;
      mem_req     <= (state_n == REQ);
      PCWre       <= (state_n == UPD);
      instr_valid <= (state_n == HOLD);
      fault       <= (state_n == FAULT);
      case (state)
        IDLE: begin
          if (state_n == REQ) begin
            fetch_pc <= Addr;
            mem_addr <= {Addr[31:2], 2'b00};
            tcount   <= '0;
          end
          if (state_n == FAULT) fault_code <= 2'b01;
        end
        REQ: begin
          if (mem_ack) begin
            instr  <= mem_rdata;
            pc_out <= fetch_pc;
          end else begin
            tcount <= tnext;
          end
          if (state_n == FAULT) fault_code <= 2'b10;
        end
        HOLD: begin
          if (instr_ready) instr_count <= instr_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
